// File: rtl/ik_swift_pkg.sv
// rtl/ik_swift_pkg.sv - shared types, state enum and saturating abs for the ik_swift iteration path
package ik_swift_pkg;

    localparam int FX_W     = 36;
    localparam int N_JOINTS = 6;

    typedef logic signed [FX_W-1:0]          fixed_t;
    typedef logic [N_JOINTS-1:0][FX_W-1:0]   joint_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } ik_iter_state_e;

    localparam fixed_t FX_MOST_NEG = {1'b1, {(FX_W-1){1'b0}}};
    localparam fixed_t FX_MAX      = {1'b0, {(FX_W-1){1'b1}}};

    // Negating the most-negative code overflows back onto itself, so clamp it.
    function automatic fixed_t fx_abs_sat(input fixed_t x);
        fixed_t r;
        if (x == FX_MOST_NEG) begin
            r = FX_MAX;
        end else if (x[FX_W-1]) begin
            r = -x;
        end else begin
            r = x;
        end
        return r;
    endfunction

endpackage

// File: rtl/ik_swift_iter_ctrl_if.sv
// rtl/ik_swift_iter_ctrl_if.sv - control, core-side and status signals of the iteration controller
interface ik_swift_iter_ctrl_if;
    import ik_swift_pkg::*;

    logic       start;
    logic       abort;
    joint_vec_t dh_init;

    logic       core_en;
    logic       core_rst;
    joint_vec_t core_dh_dyn_in;
    logic       core_done;
    joint_vec_t core_delta;
    joint_vec_t core_dh_dyn_out;

    logic       busy;
    logic       done;
    logic       converged;
    logic       timeout_err;
    logic [7:0] iter_count;
    joint_vec_t dh_result;

    modport master (
        input  start, abort, dh_init, core_done, core_delta, core_dh_dyn_out,
        output core_en, core_rst, core_dh_dyn_in,
        output busy, done, converged, timeout_err, iter_count, dh_result
    );

    modport slave (
        output start, abort, dh_init, core_done, core_delta, core_dh_dyn_out,
        input  core_en, core_rst, core_dh_dyn_in,
        input  busy, done, converged, timeout_err, iter_count, dh_result
    );

endinterface

// File: rtl/ik_delta_conv_check.sv
// rtl/ik_delta_conv_check.sv - combinational all-joints |delta| <= EPSILON test
module ik_delta_conv_check
    import ik_swift_pkg::*;
#(
    parameter fixed_t EPSILON = 36'd64
) (
    input  joint_vec_t delta_i,
    output logic       converged_o
);

    // The most-negative code is rejected outright, whatever EPSILON is.
    always_comb begin
        converged_o = 1'b1;
        for (int i = 0; i < N_JOINTS; i++) begin
            if (delta_i[i] == FX_MOST_NEG) begin
                converged_o = 1'b0;
            end else if (fx_abs_sat($signed(delta_i[i])) > EPSILON) begin
                converged_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ik_swift_iter_ctrl.sv
// rtl/ik_swift_iter_ctrl.sv - seeds and re-runs the ik_swift core until convergence, cap or watchdog
module ik_swift_iter_ctrl
    import ik_swift_pkg::*;
#(
    parameter int     W        = 36,
    parameter int     N        = 6,
    parameter fixed_t EPSILON  = 36'd64,
    parameter int     MAX_ITER = 255,
    parameter int     TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    ik_swift_iter_ctrl_if.master bus
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    if (MAX_ITER < 1 || MAX_ITER > 255) begin : g_bad_max_iter
        $error("ik_swift_iter_ctrl: MAX_ITER must lie in 1..255");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("ik_swift_iter_ctrl: TIMEOUT must be at least 2");
    end
    if (W != FX_W || N != N_JOINTS) begin : g_bad_shape
        $error("ik_swift_iter_ctrl: W/N must match ik_swift_pkg");
    end

    ik_iter_state_e  state_q, state_d;
    logic            core_en_q, core_en_d;
    logic            core_rst_q, core_rst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            conv_q, conv_d;
    logic            to_q, to_d;
    logic [7:0]      iter_q, iter_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    joint_vec_t      dh_in_q, dh_in_d;
    joint_vec_t      delta_q, delta_d;
    joint_vec_t      dyn_out_q, dyn_out_d;
    joint_vec_t      result_q, result_d;

    logic            conv_w;
    logic            abort_rst;
    logic [7:0]      iter_inc;

    ik_delta_conv_check #(
        .EPSILON (EPSILON)
    ) u_conv (
        .delta_i     (delta_q),
        .converged_o (conv_w)
    );

    always_comb begin
        state_d   = state_q;
        dh_in_d   = dh_in_q;
        delta_d   = delta_q;
        dyn_out_d = dyn_out_q;
        result_d  = result_q;
        iter_d    = iter_q;
        conv_d    = conv_q;
        to_d      = to_q;
        wdog_d    = wdog_q;
        abort_rst = 1'b0;
        iter_inc  = iter_q + 8'd1;

        if (bus.abort && state_q != ST_IDLE) begin
            state_d   = ST_IDLE;
            abort_rst = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start && !bus.abort) begin
                        state_d = ST_SEED;
                        iter_d  = '0;
                        conv_d  = 1'b0;
                        to_d    = 1'b0;
                        dh_in_d = bus.dh_init;
                    end
                end
                ST_SEED: begin
                    wdog_d  = '0;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // A done arriving on the last watchdog cycle still counts.
                    if (bus.core_done) begin
                        delta_d   = bus.core_delta;
                        dyn_out_d = bus.core_dh_dyn_out;
                        state_d   = ST_CHECK;
                    end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                        to_d     = 1'b1;
                        result_d = dh_in_q;
                        state_d  = ST_DONE;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    iter_d  = iter_inc;
                    dh_in_d = dyn_out_q;
                    if (conv_w) begin
                        conv_d   = 1'b1;
                        result_d = dyn_out_q;
                        state_d  = ST_DONE;
                    end else if (iter_inc == 8'(MAX_ITER)) begin
                        conv_d   = 1'b0;
                        result_d = dyn_out_q;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_SEED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are registered from the state being entered so they line up with it.
        core_en_d  = (state_d == ST_RUN);
        core_rst_d = (state_d == ST_SEED) || abort_rst;
        busy_d     = (state_d == ST_SEED) || (state_d == ST_RUN) || (state_d == ST_CHECK);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            core_en_q  <= 1'b0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
            to_q       <= 1'b0;
            iter_q     <= '0;
            wdog_q     <= '0;
            dh_in_q    <= '0;
            delta_q    <= '0;
            dyn_out_q  <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            core_en_q  <= core_en_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conv_q     <= conv_d;
            to_q       <= to_d;
            iter_q     <= iter_d;
            wdog_q     <= wdog_d;
            dh_in_q    <= dh_in_d;
            delta_q    <= delta_d;
            dyn_out_q  <= dyn_out_d;
            result_q   <= result_d;
        end
    end

    assign bus.core_en        = core_en_q;
    assign bus.core_rst       = core_rst_q;
    assign bus.core_dh_dyn_in = dh_in_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.converged      = conv_q;
    assign bus.timeout_err    = to_q;
    assign bus.iter_count     = iter_q;
    assign bus.dh_result      = result_q;

endmodule

// File: tb/tb_ik_swift_iter_ctrl.sv
// tb/tb_ik_swift_iter_ctrl.sv - bench for ik_swift_iter_ctrl with a behavioural ik_swift core model
module tb_ik_swift_iter_ctrl;
    import ik_swift_pkg::*;

    typedef struct packed {
        logic       en;
        logic       crst;
        logic       busy;
        logic       done;
        logic       conv;
        logic       to;
        logic [7:0] iter;
        joint_vec_t res;
        joint_vec_t dyn_in;
    } obs_t;

    typedef struct packed {
        joint_vec_t last_out;
        joint_vec_t exp_in;
        int         n_dones;
        int         rstp;
        int         feed_bad;
        int         gap_bad;
        int         first_conv;
        int         cnt;
        int         since;
        int         seen;
        logic       en_prev;
    } mst_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_r [2] = '{1'b0, 1'b0};
    logic       abort_r [2] = '{1'b0, 1'b0};
    joint_vec_t init_r  [2] = '{'0, '0};
    int         mode_r  [2] = '{0, 0};
    int         run_id  [2] = '{0, 0};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Instance 0: default limits. Instance 1: MAX_ITER=5, TIMEOUT=16.
    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int MI = (g == 0) ? 255 : 5;
        localparam int TO = (g == 0) ? 4096 : 16;

        ik_swift_iter_ctrl_if bus ();

        ik_swift_iter_ctrl #(
            .W        (36),
            .N        (6),
            .EPSILON  (36'd64),
            .MAX_ITER (MI),
            .TIMEOUT  (TO)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        obs_t       ob;
        mst_t       ms   = '0;
        logic       cd   = 1'b0;
        joint_vec_t cdel = '0;
        joint_vec_t cout = '0;

        assign bus.start           = start_r[g];
        assign bus.abort           = abort_r[g];
        assign bus.dh_init         = init_r[g];
        assign bus.core_done       = cd;
        assign bus.core_delta      = cdel;
        assign bus.core_dh_dyn_out = cout;
        assign ob = {bus.core_en, bus.core_rst, bus.busy, bus.done, bus.converged,
                     bus.timeout_err, bus.iter_count, bus.dh_result, bus.core_dh_dyn_in};

        // Core model: done after 10 enabled cycles, delta chosen by mode, random dh_dyn_out.
        always @(negedge clk) begin
            int   d;
            logic ok;
            cd = 1'b0;
            if (ms.seen != run_id[g]) begin
                ms        = '0;
                ms.seen   = run_id[g];
                ms.exp_in = init_r[g];
                ms.since  = -1;
            end
            if (ms.since >= 0) ms.since++;
            if (bus.core_rst) begin
                ms.rstp++;
                ms.cnt = 0;
            end else if (bus.core_en) begin
                if (!ms.en_prev && ms.since >= 0) begin
                    if (ms.since != 3) ms.gap_bad++;
                    ms.since = -1;
                end
                ms.cnt++;
                if (ms.cnt == 10 && mode_r[g] != 3) begin
                    cd = 1'b1;
                    if (bus.core_dh_dyn_in !== ms.exp_in) ms.feed_bad++;
                    ok = 1'b1;
                    for (int j = 0; j < N_JOINTS; j++) begin
                        case (mode_r[g])
                            0:       d = 0;
                            1:       d = (j % 2 == 1) ? -(4096 >> ms.n_dones) : (4096 >> ms.n_dones);
                            2:       d = (j == 5) ? -1000 : 1000;
                            4:       d = 0;
                            default: d = int'($urandom_range(140)) - 70;
                        endcase
                        cdel[j] = 36'(d);
                        if (d > 64 || d < -64) ok = 1'b0;
                        cout[j] = 36'({$urandom(), $urandom()});
                    end
                    if (mode_r[g] == 4) begin
                        cdel[3] = 36'h800000000;
                        ok      = 1'b0;
                    end
                    ms.n_dones++;
                    ms.exp_in   = cout;
                    ms.last_out = cout;
                    if (ok && ms.first_conv == 0) ms.first_conv = ms.n_dones;
                    ms.since = 0;
                end
            end
            ms.en_prev = bus.core_en;
        end
    end

    function automatic obs_t obs(input int g);
        if (g == 0) return g_inst[0].ob;
        return g_inst[1].ob;
    endfunction

    function automatic mst_t mstat(input int g);
        if (g == 0) return g_inst[0].ms;
        return g_inst[1].ms;
    endfunction

    function automatic joint_vec_t rand_vec();
        joint_vec_t v;
        for (int j = 0; j < N_JOINTS; j++) v[j] = 36'({$urandom(), $urandom()});
        return v;
    endfunction

    task automatic chk(input string tag, input logic [215:0] got, input logic [215:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int g, input int mode);
        obs_t o;
        mode_r[g] = mode;
        init_r[g] = rand_vec();
        run_id[g]++;
        start_r[g] = 1'b1;
        cycle(1);
        start_r[g] = 1'b0;
        o = obs(g);
        chk("start_clears_done", o.done, 1'b0);
        chk("start_clears_iter", o.iter, 8'd0);
        chk("start_seed_rst", o.crst, 1'b1);
    endtask

    task automatic wait_done(input int g, input int budget, output int cyc);
        obs_t o;
        cyc = 0;
        o   = obs(g);
        while (!o.done && cyc < budget) begin
            cycle(1);
            cyc++;
            o = obs(g);
        end
        chk("done_within_budget", o.done, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        obs_t       o;
        mst_t       m;
        int         cyc;
        int         exp_iter;
        joint_vec_t held;

        cycle(3);
        for (int g = 0; g < 2; g++) begin
            chk("reset_outputs", obs(g), '0);
        end
        rst = 1'b0;
        cycle(1);

        // Immediate convergence: latency, status and result.
        start_run(0, 0);
        o = obs(0);
        chk("t1_en_after_1", o.en, 1'b0);
        cycle(1);
        o = obs(0);
        chk("t1_en_after_2", o.en, 1'b1);
        chk("t1_busy", o.busy, 1'b1);
        wait_done(0, 200, cyc);
        o = obs(0); m = mstat(0);
        chk("t1_conv", o.conv, 1'b1);
        chk("t1_iter", o.iter, 8'd1);
        chk("t1_result", o.res, m.last_out);
        chk("t1_busy_done", o.busy, 1'b0);
        chk("t1_to", o.to, 1'b0);

        // Halving deltas from 4096 converge on the 7th iteration.
        start_run(0, 1);
        wait_done(0, 2000, cyc);
        o = obs(0); m = mstat(0);
        chk("t2_conv", o.conv, 1'b1);
        chk("t2_iter", o.iter, 8'd7);
        chk("t2_rst_pulses", m.rstp, 7);
        chk("t2_result", o.res, m.last_out);
        chk("t2_feedback", m.feed_bad, 0);
        chk("t2_gap", m.gap_bad, 0);

        // Fixed delta 1000 stops at MAX_ITER=5.
        start_run(1, 2);
        wait_done(1, 2000, cyc);
        o = obs(1); m = mstat(1);
        chk("t3_conv", o.conv, 1'b0);
        chk("t3_iter", o.iter, 8'd5);
        chk("t3_dones", m.n_dones, 5);
        chk("t3_result", o.res, m.last_out);
        chk("t3_feedback", m.feed_bad, 0);

        // Core never finishes: watchdog trips after 16 RUN cycles.
        start_run(1, 3);
        wait_done(1, 100, cyc);
        o = obs(1);
        chk("t4_latency", cyc, 17);
        chk("t4_to", o.to, 1'b1);
        chk("t4_iter", o.iter, 8'd0);
        chk("t4_conv", o.conv, 1'b0);
        chk("t4_result", o.res, init_r[1]);

        // Most-negative delta never converges.
        start_run(1, 4);
        wait_done(1, 2000, cyc);
        o = obs(1); m = mstat(1);
        chk("t5_conv", o.conv, 1'b0);
        chk("t5_iter", o.iter, 8'd5);
        chk("t5_result", o.res, m.last_out);

        // Random deltas around EPSILON against the model's abs/threshold rule.
        for (int r = 0; r < 6; r++) begin
            start_run(1, 5);
            wait_done(1, 2000, cyc);
            o = obs(1); m = mstat(1);
            exp_iter = (m.first_conv != 0) ? m.first_conv : 5;
            chk("rnd_iter", o.iter, 8'(exp_iter));
            chk("rnd_conv", o.conv, m.first_conv != 0);
            chk("rnd_result", o.res, m.last_out);
            chk("rnd_feedback", m.feed_bad, 0);
            chk("rnd_gap", m.gap_bad, 0);
        end

        // Abort mid-RUN together with start: abort wins, dh_result held.
        start_run(0, 3);
        cycle(5);
        held = obs(0).res;
        abort_r[0] = 1'b1;
        start_r[0] = 1'b1;
        cycle(1);
        abort_r[0] = 1'b0;
        start_r[0] = 1'b0;
        o = obs(0);
        chk("ab_en", o.en, 1'b0);
        chk("ab_rst", o.crst, 1'b1);
        chk("ab_busy", o.busy, 1'b0);
        chk("ab_done", o.done, 1'b0);
        chk("ab_res_held", o.res, held);
        cycle(1);
        o = obs(0);
        chk("ab_rst_one_cycle", o.crst, 1'b0);
        chk("ab_idle", o.busy, 1'b0);

        // Start and abort together while idle: nothing starts.
        abort_r[0] = 1'b1;
        start_r[0] = 1'b1;
        cycle(1);
        abort_r[0] = 1'b0;
        start_r[0] = 1'b0;
        o = obs(0);
        chk("ab2_busy", o.busy, 1'b0);
        chk("ab2_rst", o.crst, 1'b0);
        cycle(1);
        chk("ab2_en", obs(0).en, 1'b0);

        // rst while in CHECK returns every output to 0.
        start_run(0, 0);
        cyc = 0;
        while (mstat(0).n_dones == 0 && cyc < 200) begin
            cycle(1);
            cyc++;
        end
        chk("rc_reached_done", mstat(0).n_dones, 1);
        o = obs(0);
        chk("rc_in_check", {o.busy, o.en, o.crst}, 3'b100);
        rst = 1'b1;
        cycle(1);
        chk("rc_all_zero", obs(0), '0);
        rst = 1'b0;
        cycle(2);
        chk("rc_stays_idle", obs(0).busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
